// File: rtl/l1_fill_controller_if.sv
// Bundle of request/response, L1, L2 and memory signals around l1_fill_controller.
// The master modport is the controller's view; slave is the surrounding hierarchy.
interface l1_fill_controller_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STAT_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_address;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;
  logic [1:0]            resp_source;
  logic [ADDR_WIDTH-1:0] l1_address;
  logic                  l1_hit;
  logic                  l1_miss;
  logic [DATA_WIDTH-1:0] l1_data;
  logic                  l1_promote_data;
  logic [DATA_WIDTH-1:0] l1_promotion_data;
  logic                  l2_req;
  logic [ADDR_WIDTH-1:0] l2_address;
  logic                  l2_done;
  logic                  l2_hit;
  logic [DATA_WIDTH-1:0] l2_data;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [STAT_WIDTH-1:0] l1_hit_count;
  logic [STAT_WIDTH-1:0] l2_hit_count;
  logic [STAT_WIDTH-1:0] mem_count;

  modport master (
    input  req_valid, req_address,
    output req_ready, resp_valid, resp_data, resp_source,
    output l1_address, l1_promote_data, l1_promotion_data,
    input  l1_hit, l1_miss, l1_data,
    output l2_req, l2_address,
    input  l2_done, l2_hit, l2_data,
    output mem_req, mem_address,
    input  mem_ack, mem_data,
    output l1_hit_count, l2_hit_count, mem_count
  );

  modport slave (
    output req_valid, req_address,
    input  req_ready, resp_valid, resp_data, resp_source,
    input  l1_address, l1_promote_data, l1_promotion_data,
    output l1_hit, l1_miss, l1_data,
    input  l2_req, l2_address,
    output l2_done, l2_hit, l2_data,
    input  mem_req, mem_address,
    output mem_ack, mem_data,
    input  l1_hit_count, l2_hit_count, mem_count
  );
endinterface

// File: rtl/l1_fill_controller.sv
// Single-request sequencer: L1 lookup, then L2, then memory with timeout; fills L1 on a
// lower-level hit and returns the word with its source. Keeps saturating per-level counters.
module l1_fill_controller #(
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned STAT_WIDTH     = 16
) (
  input logic                  clk,
  input logic                  reset,
  l1_fill_controller_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StL1Check,
    StL2Wait,
    StMemWait,
    StPromote,
    StRespond
  } state_e;

  localparam logic [7:0]            TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [STAT_WIDTH-1:0] StatOne     = STAT_WIDTH'(1);

  state_e     state_q;
  logic [7:0] wait_q;

  // L1 miss is implied by !l1_hit during L1_CHECK; the explicit miss line is not needed.
  logic unused_l1_miss;
  assign unused_l1_miss = bus.l1_miss;

  assign bus.req_ready = (state_q == StIdle) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q               <= StIdle;
      wait_q                <= '0;
      bus.resp_valid        <= 1'b0;
      bus.resp_data         <= '0;
      bus.resp_source       <= 2'd0;
      bus.l1_address        <= '0;
      bus.l1_promote_data   <= 1'b0;
      bus.l1_promotion_data <= '0;
      bus.l2_req            <= 1'b0;
      bus.l2_address        <= '0;
      bus.mem_req           <= 1'b0;
      bus.mem_address       <= '0;
      bus.l1_hit_count      <= '0;
      bus.l2_hit_count      <= '0;
      bus.mem_count         <= '0;
    end else begin
      bus.resp_valid      <= 1'b0;
      bus.l1_promote_data <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            bus.l1_address  <= bus.req_address;
            bus.l2_address  <= bus.req_address;
            bus.mem_address <= bus.req_address;
            state_q         <= StL1Check;
          end
        end
        StL1Check: begin
          if (bus.l1_hit) begin
            bus.resp_data   <= bus.l1_data;
            bus.resp_source <= 2'd0;
            bus.resp_valid  <= 1'b1;
            if (bus.l1_hit_count != '1) bus.l1_hit_count <= bus.l1_hit_count + StatOne;
            state_q <= StRespond;
          end else begin
            bus.l2_req <= 1'b1;
            state_q    <= StL2Wait;
          end
        end
        StL2Wait: begin
          if (bus.l2_done) begin
            bus.l2_req <= 1'b0;
            if (bus.l2_hit) begin
              bus.resp_data         <= bus.l2_data;
              bus.l1_promotion_data <= bus.l2_data;
              bus.resp_source       <= 2'd1;
              bus.l1_promote_data   <= 1'b1;
              if (bus.l2_hit_count != '1) bus.l2_hit_count <= bus.l2_hit_count + StatOne;
              state_q <= StPromote;
            end else begin
              bus.mem_req <= 1'b1;
              wait_q      <= '0;
              state_q     <= StMemWait;
            end
          end
        end
        StMemWait: begin
          // An ack in the last allowed cycle takes priority over the timeout.
          if (bus.mem_ack) begin
            bus.mem_req           <= 1'b0;
            bus.resp_data         <= bus.mem_data;
            bus.l1_promotion_data <= bus.mem_data;
            bus.resp_source       <= 2'd2;
            bus.l1_promote_data   <= 1'b1;
            if (bus.mem_count != '1) bus.mem_count <= bus.mem_count + StatOne;
            state_q <= StPromote;
          end else if (wait_q == TimeoutLast) begin
            bus.mem_req     <= 1'b0;
            bus.resp_data   <= '0;
            bus.resp_source <= 2'd3;
            bus.resp_valid  <= 1'b1;
            state_q         <= StRespond;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StPromote: begin
          bus.resp_valid <= 1'b1;
          state_q        <= StRespond;
        end
        StRespond: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/l1_fill_controller.md
# l1_fill_controller

Request sequencer that sits directly upstream of `l1_cache`. It accepts one 11-bit read request at a time, drives the L1 lookup address, and on an L1 miss walks down to L2 and then main memory. It then drives `promote_data`/`promotion_data` into L1 for exactly one cycle and returns the data to the requester. It also keeps saturating hit statistics for each hierarchy level.

## Interface
- `ADDR_WIDTH`, 11: request / cache address width; must match `l1_cache`.
- `DATA_WIDTH`, 32: data word width.
- `TIMEOUT_CYCLES`, 255: maximum MEM_WAIT cycles before an error response; legal range 1..255.
- `STAT_WIDTH`, 16: width of each statistics counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept; combinational, equal to (state==IDLE && !reset).
- `req_address`  in  ADDR_WIDTH  request address.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_data`  out  DATA_WIDTH  response data.
- `resp_source`  out  2  0=L1, 1=L2, 2=MEM, 3=timeout error.
- `l1_address`  out  ADDR_WIDTH  registered address to `l1_cache.address`.
- `l1_hit`, `l1_miss`  in  1  from `l1_cache`.
- `l1_data`  in  DATA_WIDTH  `l1_cache.data_out`.
- `l1_promote_data`  out  1  one-cycle fill strobe.
- `l1_promotion_data`  out  DATA_WIDTH  fill word.
- `l2_req`  out  1  L2 lookup request; level signal.
- `l2_address`  out  ADDR_WIDTH  L2 lookup address.
- `l2_done`  in  1  L2 result valid.
- `l2_hit`  in  1  qualified by `l2_done`.
- `l2_data`  in  DATA_WIDTH  qualified by `l2_done && l2_hit`.
- `mem_req`  out  1  memory read request; level signal.
- `mem_address`  out  ADDR_WIDTH  memory address.
- `mem_ack`  in  1  memory data valid.
- `mem_data`  in  DATA_WIDTH  qualified by `mem_ack`.
- `l1_hit_count`, `l2_hit_count`, `mem_count`  out  STAT_WIDTH  saturating event counters.

## Operation
- States: IDLE, L1_CHECK, L2_WAIT, MEM_WAIT, PROMOTE, RESPOND.
- IDLE: on `req_valid && req_ready`, latch `req_address` into `l1_address`, `l2_address` and `mem_address`, then go to L1_CHECK. The address registers hold until the next acceptance.
- L1_CHECK: lasts one cycle. L1 has settled combinationally on `l1_address` at this point.
  - If `l1_hit`: latch `l1_data`, set source 0, increment `l1_hit_count`, go to RESPOND.
  - Otherwise: go to L2_WAIT.
- L2_WAIT: `l2_req`=1.
  - On `l2_done && l2_hit`: latch `l2_data`, set source 1, increment `l2_hit_count`, go to PROMOTE.
  - On `l2_done && !l2_hit`: go to MEM_WAIT.
  - `l2_req` drops on the same edge as the transition out of L2_WAIT.
- MEM_WAIT: `mem_req`=1, and an 8-bit wait counter clears on entry.
  - On `mem_ack`: latch `mem_data`, set source 2, increment `mem_count`, go to PROMOTE.
  - Timeout: if the counter reaches TIMEOUT_CYCLES-1 without `mem_ack`, set `resp_data`=0, source 3, and go to RESPOND without a fill.
  - If `mem_ack` arrives in the final cycle, the ack wins over the timeout.
- PROMOTE: `l1_promote_data`=1 for exactly one cycle with `l1_promotion_data` = latched word. `l1_address` is unchanged, so L1 fills the correct set. Then go to RESPOND.
- RESPOND: `resp_valid`=1 for one cycle with the latched data and source, then go to IDLE. There is no response backpressure.
- Stray inputs are ignored:
  - `l2_done` outside L2_WAIT.
  - `mem_ack` outside MEM_WAIT, including a late ack after a timeout.
  - `l1_hit`/`l1_miss` outside L1_CHECK.
- Statistics counters saturate at all-ones and never wrap.

## Timing
- Reset, at the clock edge with `reset`=1:
  - State returns to IDLE.
  - All registered outputs clear to 0: `resp_*`, `l1_address`, `l1_promote_data`, `l1_promotion_data`, `l2_*`, `mem_*`, all counters.
  - Reset mid-operation aborts the transaction. `l2_req`/`mem_req` are low in the cycle after the reset edge, and no fill or response is produced.
- Let edge E be the acceptance edge.
- L1 hit: `resp_valid` is high in the cycle after edge E+1, which is 2 cycles after acceptance.
- L2 hit:
  - `l2_req` rises after E+1.
  - With `l2_done` sampled at edge E+1+k, the fill strobe is in the cycle after E+1+k and `resp_valid` in the next cycle.
- Memory: the fill strobe follows the `mem_ack` edge by one cycle, and `resp_valid` follows one cycle later.
- `req_ready` is low from the cycle after E until the cycle after the RESPOND edge. Back-to-back requests therefore see one IDLE cycle between responses.

## Test plan
- Reset, then request 0x155 with L1 returning hit and data 0xDEADBEEF → `resp_valid` 2 cycles after acceptance, source 0, `l1_hit_count`=1, no `l1_promote_data`.
- L1 miss, L2 asserts `l2_done`+`l2_hit` 3 cycles after `l2_req` with data 0x12345678 → one-cycle promote with 0x12345678 at address 0x155, then response source 1. A repeat request then hits in L1.
- L1 miss, L2 miss, `mem_ack` after 10 cycles with 0xCAFEF00D → promote then response source 2, `mem_count`=1.
- L1 miss, L2 miss, no `mem_ack`, TIMEOUT_CYCLES=8 → after 8 MEM_WAIT cycles, response source 3 with data 0 and no promote. A late `mem_ack` is ignored and the next request is accepted normally.
- Assert `reset` during MEM_WAIT → `mem_req` is 0 the next cycle, no response, `req_ready`=1 after reset drops. Also verify that `l1_hit_count` preloaded to 0xFFFF stays at 0xFFFF on a further hit.
